cnn_state_update: RTL and testbench
===================================

CNN_STATE_UPDATE -- requirements
Module: cnn_state_update

Interface
REQ-001 Parameter WIDTH, default 9: template/input width; state width DW = 2*WIDTH-1 (17).
REQ-002 Parameter ONE, default 128: fixed-point +1.0; the output saturates at +/-ONE.
REQ-003 Parameter NCELLS, default 64: cells per frame (one iteration pass).
REQ-004 Parameter MAX_ITER, default 32: iteration limit.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins a run when idle.
REQ-008 in_valid  in  1  in_x/in_yprev valid.
REQ-009 in_ready  out  1  block accepts a cell this cycle.
REQ-010 in_x  in  DW signed  Xnew of the current cell from the A*Y+B*U+I equation stage.
REQ-011 in_yprev  in  DW signed  current stored Y of the same cell.
REQ-012 out_valid  out  1  out_y/out_addr valid.
REQ-013 out_ready  in  1  Y-memory writeback accepts.
REQ-014 out_y  out  DW signed  new saturated Y.
REQ-015 out_addr  out  clog2(NCELLS)  cell index for writeback.
REQ-016 busy, done, converged  out  1 each  run status.
REQ-017 iter_count  out  clog2(MAX_ITER+1)  completed iterations.

Function
REQ-018 FSM states: IDLE, RUN, FLUSH, DONE; start in IDLE or DONE -> RUN, clears done/converged/iter_count/counters; start in RUN or FLUSH is ignored.
REQ-019 Transfer on input occurs when in_valid && in_ready; in_ready = (state==RUN) && in_cnt<NCELLS && pipeline may advance.
REQ-020 The pipeline is 2 stages with global stall: it advances when !out_valid || out_ready; a transfer at cycle t yields out_valid at t+2 with no stall.
REQ-021 Stage 1 computes y = clamp(in_x, -ONE, +ONE) (inclusive) and registers y, in_yprev and the cell index.
REQ-022 Stage 2 registers out_y, out_addr and the change flag (y != yprev).
REQ-023 out_addr runs 0..NCELLS-1 in acceptance order and restarts at 0 each iteration.
REQ-024 out_y/out_addr hold stable while out_valid && !out_ready.
REQ-025 out_cnt counts output handshakes; chg_cnt counts handshakes with the change flag set.
REQ-026 After NCELLS inputs are accepted, state goes RUN -> FLUSH and in_ready stays low.
REQ-027 When out_cnt reaches NCELLS, iter_count increments and end-of-frame is evaluated.
REQ-028 End-of-frame with chg_cnt==0 (including the last cell) -> DONE with converged=1.
REQ-029 Otherwise, iter_count==MAX_ITER -> DONE with converged=0.
REQ-030 Otherwise -> RUN, clearing in_cnt/out_cnt/chg_cnt.
REQ-031 done=1 only in DONE, held until start or reset; busy=1 in RUN and FLUSH.
REQ-032 Boundaries: in_x exactly +/-ONE passes unchanged; in_x = -65536 yields -ONE; in_valid while in IDLE/DONE is not accepted.

Reset
REQ-033 Reset takes priority over start and handshakes, from any state including mid-frame.
REQ-034 Reset -> IDLE: all counters 0; out_valid, in_ready, busy, done, converged = 0; out_y = 0; out_addr = 0; pipeline valids cleared, in-flight cells discarded.

Structure
REQ-035 The shared package holds WIDTH, DW, the default ONE, the FSM state enum and the saturation function.
REQ-036 A sub-module cnn_sat (combinational clamp, DW in/out, ONE parameter) is instantiated in stage 1.

Verification
REQ-037 NCELLS=4, out_ready=1, in_x={300,-300,50,-128}, yprev={0,0,0,0} -> out_y={128,-128,50,-128} with addr 0..3, each 2 cycles after its accept; not converged; iteration 2 follows.
REQ-038 Second pass with yprev equal to the previous outputs -> done=1, converged=1, iter_count=2, in_ready=0.
REQ-039 Every pass has a changing cell, MAX_ITER=3 -> done=1, converged=0, iter_count=3.
REQ-040 out_ready held low for 5 cycles with out_valid=1 -> out_y/out_addr stable; in_ready low once both stages are full; no loss or duplication of cells.
REQ-041 Reset asserted after 2 of 4 cells accepted -> next cycle IDLE with all outputs 0; a new start restarts at addr 0.
REQ-042 start pulsed during RUN -> ignored, iteration count unaffected; in_x = +/-128 and +/-129 -> outputs +/-128.

Source files
------------

// File: rtl/cnn_state_update_pkg.sv
// Shared definitions for the CNN state-update block: default widths,
// the fixed-point +1.0 constant, FSM state codes and the output clamp.
package cnn_state_update_pkg;

    localparam int WIDTH       = 9;
    localparam int DW          = 2 * WIDTH - 1;
    localparam int ONE_DEFAULT = 128;

    // Run-control FSM states, kept as plain constants so older code that
    // compares against raw 2-bit values keeps working.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Inclusive clamp of x to [-one, +one]; works on sign-extended values so
    // any state width up to 32 bits can share it.
    function automatic int sat_int(input int x, input int one);
        if (x > one) begin
            return one;
        end else if (x < -one) begin
            return -one;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/cnn_state_update_sat.sv
// Combinational output clamp: limits a cell state to the range [-ONE, +ONE].
module cnn_sat #(
    parameter int DW  = cnn_state_update_pkg::DW,
    parameter int ONE = cnn_state_update_pkg::ONE_DEFAULT
) (
    input  logic signed [DW-1:0] x,
    output logic signed [DW-1:0] y
);
    import cnn_state_update_pkg::*;

    // Widen to int, clamp, and narrow back; the result always fits in DW.
    always_comb begin
        y = DW'(sat_int(int'(x), ONE));
    end

endmodule

// File: rtl/cnn_state_update.sv
// CNN cell state update: clamps each cell's new state, tags whether it
// changed since the previous pass, streams it back to Y memory, and runs
// whole-frame iterations until nothing changes or the iteration limit hits.
module cnn_state_update #(
    parameter int WIDTH    = cnn_state_update_pkg::WIDTH,
    parameter int ONE      = cnn_state_update_pkg::ONE_DEFAULT,
    parameter int NCELLS   = 64,
    parameter int MAX_ITER = 32,
    localparam int DW = 2 * WIDTH - 1,
    localparam int AW = (NCELLS > 1) ? $clog2(NCELLS) : 1,
    localparam int IW = $clog2(MAX_ITER + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_x,
    input  logic signed [DW-1:0] in_yprev,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_y,
    output logic [AW-1:0]        out_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [IW-1:0]        iter_count
);
    import cnn_state_update_pkg::*;

    localparam int CW = $clog2(NCELLS + 1);
    localparam logic [CW-1:0] NCELLS_C = CW'(NCELLS);
    localparam logic [CW-1:0] LAST_C   = CW'(NCELLS - 1);
    localparam logic [IW-1:0] MAX_C    = IW'(MAX_ITER);

    logic [1:0]           state;
    logic [CW-1:0]        in_cnt;
    logic [CW-1:0]        out_cnt;
    logic [CW-1:0]        chg_cnt;

    logic                 s1_valid;
    logic signed [DW-1:0] s1_y;
    logic signed [DW-1:0] s1_yprev;
    logic [AW-1:0]        s1_addr;
    logic                 out_chg;

    logic signed [DW-1:0] sat_y;
    logic                 advance;
    logic                 accept;
    logic                 out_hs;
    logic                 frame_end;
    logic                 frame_quiet;
    logic [IW-1:0]        iter_next;

    cnn_sat #(
        .DW  (DW),
        .ONE (ONE)
    ) u_sat (
        .x (in_x),
        .y (sat_y)
    );

    // Handshake and end-of-frame decode shared by the pipeline and the FSM.
    always_comb begin
        advance     = !out_valid || out_ready;
        in_ready    = (state == ST_RUN) && (in_cnt < NCELLS_C) && advance;
        accept      = in_valid && in_ready;
        out_hs      = out_valid && out_ready;
        frame_end   = out_hs && (out_cnt == LAST_C);
        frame_quiet = (chg_cnt == '0) && !out_chg;
        iter_next   = iter_count + IW'(1);
        busy        = (state == ST_RUN) || (state == ST_FLUSH);
        done        = (state == ST_DONE);
    end

    // Two-stage datapath with one global stall: stage 1 holds the clamped
    // value, stage 2 drives the writeback port and the change flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_y      <= '0;
            s1_yprev  <= '0;
            s1_addr   <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_addr  <= '0;
            out_chg   <= 1'b0;
        end else if (advance) begin
            s1_valid  <= accept;
            if (accept) begin
                s1_y     <= sat_y;
                s1_yprev <= in_yprev;
                s1_addr  <= in_cnt[AW-1:0];
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_y    <= s1_y;
                out_addr <= s1_addr;
                out_chg  <= (s1_y != s1_yprev);
            end
        end
    end

    // Run control: counts accepted and written cells, and at the end of each
    // frame decides between another pass, convergence, or giving up.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            in_cnt     <= '0;
            out_cnt    <= '0;
            chg_cnt    <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        in_cnt     <= '0;
                        out_cnt    <= '0;
                        chg_cnt    <= '0;
                        iter_count <= '0;
                        converged  <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        in_cnt <= in_cnt + CW'(1);
                        if (in_cnt == LAST_C) begin
                            state <= ST_FLUSH;
                        end
                    end
                    if (frame_end) begin
                        iter_count <= iter_next;
                        in_cnt     <= '0;
                        out_cnt    <= '0;
                        chg_cnt    <= '0;
                        if (frame_quiet) begin
                            state     <= ST_DONE;
                            converged <= 1'b1;
                        end else if (iter_next == MAX_C) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else if (out_hs) begin
                        out_cnt <= out_cnt + CW'(1);
                        chg_cnt <= chg_cnt + CW'(out_chg);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_state_update.sv
// Randomized self-checking bench for cnn_state_update (4 cells, 3 iterations).
module tb_cnn_state_update;

    localparam int N    = 4;
    localparam int MAXI = 3;
    localparam int DW   = 17;
    localparam int ONE  = 128;

    typedef struct {
        int y;
        int addr;
        int accCyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_x;
    logic signed [DW-1:0] in_yprev;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_y;
    logic [1:0]           out_addr;
    logic                 busy;
    logic                 done;
    logic                 converged;
    logic [1:0]           iter_count;

    int   checkCount = 0;
    int   passCount  = 0;
    int   cyc        = 0;
    int   ymem[N];
    int   xs[N];
    exp_t expQ[$];

    cnn_state_update #(
        .NCELLS   (N),
        .MAX_ITER (MAXI)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_yprev   (in_yprev),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_addr   (out_addr),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .iter_count (iter_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int clampRef(input int x);
        if (x > ONE)  return ONE;
        if (x < -ONE) return -ONE;
        return x;
    endfunction

    function automatic int genX(input int mode, input int frame, input int k);
        int v;
        v = 0;
        case (mode)
            0: case (k)
                   0: v = 300;
                   1: v = -300;
                   2: v = 50;
                   default: v = -128;
               endcase
            1: if (k == 0) v = (frame % 2 == 1) ? 100 : -100;
               else        v = int'($urandom_range(0, 400)) - 200;
            2: v = int'($urandom_range(0, 300)) - 150;
            default:
               if (frame == 0) begin
                   case (k)
                       0: v = 128;
                       1: v = -128;
                       2: v = 129;
                       default: v = -129;
                   endcase
               end else begin
                   case (k)
                       0: v = -65536;
                       1: v = 65535;
                       2: v = -129;
                       default: v = 129;
                   endcase
               end
        endcase
        return v;
    endfunction

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs a complete job: feeds frames until the model says the run is over.
    // mode 0: fixed table, full-rate; 1: random, always changing;
    // 2: random with a 5-cycle writeback stall; 3: boundary values + stray start.
    task automatic applyStimulus(input int mode);
        int  frame, iter, i, outCnt, budget, stallLeft, yHold, aHold;
        bit  expDone, expConv, changed, stallDone;
        exp_t e;
        frame = 0; iter = 0; expDone = 0; expConv = 0;
        stallLeft = 0; stallDone = 0; yHold = 0; aHold = 0;
        for (int k = 0; k < N; k++) ymem[k] = 0;
        pulseStart();
        while (!expDone) begin
            for (int k = 0; k < N; k++) xs[k] = genX(mode, frame, k);
            expQ.delete();
            i = 0; outCnt = 0; budget = 0;
            while (outCnt < N && budget < 80) begin
                @(negedge clk);
                cyc++;
                budget++;
                start    = (mode == 3 && frame == 0 && budget == 2);
                in_valid = (i < N) && ((mode == 0 || mode == 3) ? 1'b1 : ($urandom_range(0, 3) != 0));
                in_x     = DW'(xs[i % N]);
                in_yprev = DW'(ymem[i % N]);
                if (mode == 2 && !stallDone && stallLeft == 0 && out_valid) begin
                    stallLeft = 5;
                    yHold     = int'(out_y);
                    aHold     = int'(out_addr);
                end
                if (stallLeft > 0) out_ready = 1'b0;
                else               out_ready = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
                #1;
                if (stallLeft > 0) begin
                    checkOutput("stall_out_y", int'(out_y), yHold);
                    checkOutput("stall_out_addr", int'(out_addr), aHold);
                    checkOutput("stall_out_valid", int'(out_valid), 1);
                    checkOutput("stall_in_ready", int'(in_ready), 0);
                    stallLeft--;
                    if (stallLeft == 0) stallDone = 1;
                end
                if (in_valid && in_ready) begin
                    expQ.push_back('{clampRef(xs[i]), i, cyc});
                    i++;
                end
                if (out_valid && out_ready) begin
                    checkOutput("out_pending", int'(expQ.size() > 0), 1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput("out_y", int'(out_y), e.y);
                        checkOutput("out_addr", int'(out_addr), e.addr);
                        if (mode == 0) checkOutput("latency", cyc - e.accCyc, 2);
                    end
                    outCnt++;
                end
            end
            checkOutput("frame_outputs", outCnt, N);
            changed = 0;
            for (int k = 0; k < N; k++) begin
                if (clampRef(xs[k]) != ymem[k]) changed = 1;
                ymem[k] = clampRef(xs[k]);
            end
            iter++;
            expConv = !changed;
            expDone = !changed || (iter == MAXI);
            @(negedge clk);
            start     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            checkOutput("done", int'(done), int'(expDone));
            checkOutput("converged", int'(converged), int'(expDone && expConv));
            checkOutput("iter_count", int'(iter_count), iter);
            checkOutput("busy", int'(busy), int'(!expDone));
            checkOutput("in_ready_frame_end", int'(in_ready), int'(!expDone));
            frame++;
        end
    endtask

    // Reset in the middle of a frame, then confirm IDLE ignores input.
    task automatic resetMidFrame();
        int acc, budget;
        acc = 0; budget = 0;
        pulseStart();
        while (acc < 2 && budget < 20) begin
            @(negedge clk);
            budget++;
            in_valid  = 1'b1;
            in_x      = DW'(int'($urandom_range(0, 600)) - 300);
            in_yprev  = '0;
            out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) acc++;
        end
        checkOutput("reset_pre_accepts", acc, 2);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_y", int'(out_y), 0);
        checkOutput("rst_out_addr", int'(out_addr), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_converged", int'(converged), 0);
        checkOutput("rst_iter_count", int'(iter_count), 0);
        checkOutput("rst_in_ready", int'(in_ready), 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            checkOutput("idle_in_ready", int'(in_ready), 0);
            checkOutput("idle_out_valid", int'(out_valid), 0);
        end
        in_valid = 1'b0;
    endtask

    // Test sequence
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_yprev  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("init_out_valid", int'(out_valid), 0);
        checkOutput("init_busy", int'(busy), 0);
        checkOutput("init_done", int'(done), 0);
        checkOutput("init_iter_count", int'(iter_count), 0);
        reset = 1'b0;
        applyStimulus(0);
        applyStimulus(1);
        applyStimulus(2);
        applyStimulus(3);
        resetMidFrame();
        applyStimulus(1);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
